fetch_stage: RTL and testbench

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage 16-bit core. Owns the PC, issues one-outstanding-request fetches to instruction memory, and presents the fetched instruction to decode. Obeys the hazard unit's hold (`stall`) and flush (`flush`, asserted on taken branch/jump) together with the redirect target. Handles variable-latency memory, discards stale responses after a redirect, and parks on HALT.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_if_id_reg.sv | 45 ++++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: datapath width, bubble encoding, reset PC and FSM states.
package fetch_stage_pkg;

    localparam int unsigned XLEN = 16;

    typedef logic [XLEN-1:0] word_t;

    localparam word_t NOP_INSTR = 16'h0800;
    localparam word_t RESET_PC  = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_BUF,
        ST_DRAIN,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a new instruction, insert a bubble, or hold.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter word_t NOP = NOP_INSTR
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  logic  bubble_i,
    input  word_t instr_i,
    input  word_t pc_i,
    output word_t instr_o,
    output word_t pc_o,
    output word_t pc2_o,
    output logic  valid_o
);

    word_t instr_q, pc_q, pc2_q;
    logic  valid_q;

    // A bubble keeps the PC fields so decode still sees a coherent address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q <= NOP;
            pc_q    <= '0;
            pc2_q   <= 16'h0002;
            valid_q <= 1'b0;
        end else if (bubble_i) begin
            instr_q <= NOP;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            pc2_q   <= pc_i + 16'h0002;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc2_o   = pc2_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, one-outstanding imem request FSM, stall buffer and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t RESET_PC_P  = RESET_PC,
    parameter word_t NOP_INSTR_P = NOP_INSTR
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  stall,
    input  logic  flush,
    input  word_t redirect_pc,
    input  logic  halt_dec,
    output logic  imem_req,
    output word_t imem_addr,
    input  logic  imem_ready,
    input  word_t imem_rdata,
    output word_t if_id_instr,
    output word_t if_id_pc,
    output word_t if_id_pc2,
    output logic  if_id_valid,
    output logic  halted
);

    fetch_state_e state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        buf_instr_q, buf_instr_d;
    word_t        buf_pc_q, buf_pc_d;
    logic         halt_pend_q, halt_pend_d;
    logic         halted_q;

    logic  load, bubble;
    word_t ld_instr, ld_pc;
    logic  waiting;

    // A request is still in flight when it has not been answered this cycle.
    assign waiting = (state_q == ST_FETCH || state_q == ST_DRAIN) && !imem_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        halt_pend_d = halt_pend_q;
        load        = 1'b0;
        bubble      = 1'b0;
        ld_instr    = imem_rdata;
        ld_pc       = pc_q;

        if (state_q != ST_HALT && flush) begin
            bubble      = 1'b1;
            pc_d        = redirect_pc;
            buf_instr_d = '0;
            buf_pc_d    = '0;
            halt_pend_d = 1'b0;
            state_d     = waiting ? ST_DRAIN : ST_FETCH;
        end else if (state_q != ST_HALT && halt_dec) begin
            bubble      = 1'b1;
            buf_instr_d = '0;
            buf_pc_d    = '0;
            halt_pend_d = waiting;
            state_d     = waiting ? ST_DRAIN : ST_HALT;
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (imem_ready) begin
                        pc_d = pc_q + 16'h0002;
                        if (stall) begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = pc_q;
                            state_d     = ST_BUF;
                        end else begin
                            load = 1'b1;
                        end
                    end else if (!stall) begin
                        bubble = 1'b1;
                    end
                end
                ST_BUF: begin
                    if (!stall) begin
                        load     = 1'b1;
                        ld_instr = buf_instr_q;
                        ld_pc    = buf_pc_q;
                        state_d  = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    bubble = 1'b1;
                    if (imem_ready) begin
                        state_d     = halt_pend_q ? ST_HALT : ST_FETCH;
                        halt_pend_d = 1'b0;
                    end
                end
                ST_HALT: begin
                    bubble = 1'b1;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC_P;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            halt_pend_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            halt_pend_q <= halt_pend_d;
            halted_q    <= (state_d == ST_HALT);
        end
    end

    assign imem_req  = rst && (state_q == ST_FETCH || state_q == ST_DRAIN);
    assign imem_addr = pc_q;
    assign halted    = halted_q;

    if_id_reg #(
        .NOP (NOP_INSTR_P)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load),
        .bubble_i (bubble),
        .instr_i  (ld_instr),
        .pc_i     (ld_pc),
        .instr_o  (if_id_instr),
        .pc_o     (if_id_pc),
        .pc2_o    (if_id_pc2),
        .valid_o  (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, halt_dec, imem_ready;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr, imem_rdata;
    logic [15:0] if_id_instr, if_id_pc, if_id_pc2;
    logic        if_id_valid, halted;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .halt_dec    (halt_dec),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .if_id_pc2   (if_id_pc2),
        .if_id_valid (if_id_valid),
        .halted      (halted)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the fetcher either has a live request for m_pc, a stale
    // request it must throw away, a parked instruction, or has halted.
    logic [15:0] m_pc, m_buf_instr, m_buf_pc, e_instr, e_pc;
    bit          m_halted, m_stale, m_halt_after, m_buffered, e_valid;

    task automatic model_reset();
        m_pc = 16'h0000; m_halted = 0; m_stale = 0; m_halt_after = 0; m_buffered = 0;
        m_buf_instr = 0; m_buf_pc = 0;
        e_instr = 16'h0800; e_pc = 16'h0000; e_valid = 0;
    endtask

    task automatic make_bubble();
        e_instr = 16'h0800;
        e_valid = 0;
    endtask

    task automatic model_update(input bit fl, input logic [15:0] rpc, input bit hd, input bit st, input bit rdy);
        bit in_flight;
        in_flight = !m_halted && !m_buffered && !rdy;
        if (m_halted) begin
            make_bubble();
        end else if (fl) begin
            make_bubble();
            m_pc = rpc; m_buffered = 0; m_stale = in_flight; m_halt_after = 0;
        end else if (hd) begin
            make_bubble();
            m_buffered = 0;
            if (in_flight) begin
                m_stale = 1; m_halt_after = 1;
            end else begin
                m_stale = 0; m_halted = 1;
            end
        end else if (m_stale) begin
            make_bubble();
            if (rdy) begin
                m_stale = 0;
                if (m_halt_after) m_halted = 1;
                m_halt_after = 0;
            end
        end else if (m_buffered) begin
            if (!st) begin
                e_instr = m_buf_instr; e_pc = m_buf_pc; e_valid = 1; m_buffered = 0;
            end
        end else if (rdy) begin
            if (st) begin
                m_buffered = 1; m_buf_instr = mem_word(m_pc); m_buf_pc = m_pc;
            end else begin
                e_instr = mem_word(m_pc); e_pc = m_pc; e_valid = 1;
            end
            m_pc = m_pc + 16'h0002;
        end else if (!st) begin
            make_bubble();
        end
    endtask

    task automatic compare_all();
        check("imem_req", 16'(imem_req), 16'(!m_halted && !m_buffered));
        check("imem_addr", imem_addr, m_pc);
        check("if_id_instr", if_id_instr, e_instr);
        check("if_id_pc", if_id_pc, e_pc);
        check("if_id_pc2", if_id_pc2, e_pc + 16'h0002);
        check("if_id_valid", 16'(if_id_valid), 16'(e_valid));
        check("halted", 16'(halted), 16'(m_halted));
    endtask

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic step(input bit fl, input logic [15:0] rpc, input bit hd, input bit st, input bit rdy);
        flush = fl; redirect_pc = rpc; halt_dec = hd; stall = st; imem_ready = rdy;
        model_update(fl, rpc, hd, st, rdy);
        @(negedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_req", 16'(imem_req), 16'h0000);
        check("arst_valid", 16'(if_id_valid), 16'h0000);
        check("arst_pc", if_id_pc, 16'h0000);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b0; stall = 0; flush = 0; halt_dec = 0; imem_ready = 0; redirect_pc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_instr", if_id_instr, 16'h0800);
        check("rst_pc", if_id_pc, 16'h0000);
        check("rst_pc2", if_id_pc2, 16'h0002);
        check("rst_valid", 16'(if_id_valid), 16'h0000);
        check("rst_req", 16'(imem_req), 16'h0000);
        rst = 1'b1;
        #1;
        check("first_req", 16'(imem_req), 16'h0001);
        compare_all();

        // Zero-wait memory: one instruction per cycle.
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 1);
            check("zw_pc", if_id_pc, 16'(2 * i));
            check("zw_valid", 16'(if_id_valid), 16'h0001);
        end

        // Two wait cycles then data.
        step(0, 0, 0, 0, 0);
        check("ws_addr", imem_addr, 16'h000C);
        step(0, 0, 0, 0, 0);
        check("ws_bubble", 16'(if_id_valid), 16'h0000);
        step(0, 0, 0, 0, 1);
        check("ws_pc", if_id_pc, 16'h000C);

        // Accept under stall, hold three cycles, release.
        step(0, 0, 0, 1, 1);
        check("buf_req", 16'(imem_req), 16'h0000);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        check("buf_frozen", if_id_pc, 16'h000C);
        step(0, 0, 0, 0, 0);
        check("buf_out", if_id_pc, 16'h000E);
        step(0, 0, 0, 0, 1);
        check("buf_next", if_id_pc, 16'h0010);

        // Flush while a request is pending; stale response must be dropped.
        step(0, 0, 0, 0, 0);
        step(1, 16'h0040, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("drain_bubble", 16'(if_id_valid), 16'h0000);
        step(0, 0, 0, 0, 1);
        check("redir_pc", if_id_pc, 16'h0040);
        step(1, 16'h0080, 0, 1, 1);
        check("flush_stall", 16'(if_id_valid), 16'h0000);
        step(0, 0, 0, 0, 1);
        check("flush_stall_pc", if_id_pc, 16'h0080);

        // PC wrap.
        step(1, 16'hFFFE, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("wrap_addr", imem_addr, 16'h0000);
        check("wrap_pc", if_id_pc, 16'hFFFE);

        for (int i = 0; i < 400; i++)
            step(($urandom % 16) == 0, 16'($urandom) & 16'hFFFE, 0,
                 ($urandom % 4) == 0, ($urandom % 2) == 0);

        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);

        // HALT with a request in flight: drain first, then park.
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("halt_drain", 16'(halted), 16'h0000);
        step(0, 0, 0, 0, 1);
        check("halted", 16'(halted), 16'h0001);
        check("halt_req", 16'(imem_req), 16'h0000);
        for (int i = 0; i < 3; i++) step(1, 16'h0100, 0, 0, 1);
        check("halt_addr", imem_addr, 16'h0006);
        do_reset();
        step(0, 0, 0, 0, 1);
        check("restart_pc", if_id_pc, 16'h0000);
        check("restart_valid", 16'(if_id_valid), 16'h0001);

        for (int i = 0; i < 600; i++) begin
            if (m_halted && ($urandom % 8) == 0) do_reset();
            step(($urandom % 16) == 0, 16'($urandom) & 16'hFFFE, ($urandom % 48) == 0,
                 ($urandom % 4) == 0, ($urandom % 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
